// File: rtl/sixteen_bit_up_counter_pkg.sv
// Shared definitions for the sixteen-bit up counter: data width and FSM state encodings.
package sixteen_bit_up_counter_pkg;

    // Counter, target and load width. Only 16 is supported.
    localparam int CNT_W = 16;

    // Controller states; the encodings are fixed so the bench can name them too.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_add.sv
// One-bit full adder cell used to build the ripple incrementer.
module full_add (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum and carry of three one-bit operands.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/sixteen_bit_incrementer.sv
// Ripple incrementer: s = a + 1, cout is the carry out of the top bit
// (set only when a is all ones, i.e. the value wraps to zero).
module sixteen_bit_incrementer
    import sixteen_bit_up_counter_pkg::*;
(
    input  logic [CNT_W-1:0] a,
    output logic [CNT_W-1:0] s,
    output logic             cout
);

    // carry[0] is the "+1" injected at the bottom of the chain.
    logic [CNT_W:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < CNT_W; i++) begin : g_stage
        full_add u_fa (
            .a    (a[i]),
            .b    (1'b0),
            .cin  (carry[i]),
            .s    (s[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[CNT_W];

endmodule

// File: rtl/sixteen_bit_up_counter.sv
// Loadable 16-bit up counter with start/stop control, terminal-value detection,
// wrap pulse and sticky overflow flag. All outputs come straight from flops.
module sixteen_bit_up_counter
    import sixteen_bit_up_counter_pkg::*;
#(
    parameter int WIDTH = CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic             stop,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic             ovf
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] next_target;
    logic             wrap_evt;
    logic [WIDTH-1:0] inc_s;
    logic             inc_cout;

    sixteen_bit_incrementer u_inc (
        .a    (count),
        .s    (inc_s),
        .cout (inc_cout)
    );

    // State, count and sampled target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            count    <= '0;
            target_q <= '0;
        end else begin
            state    <= next_state;
            count    <= next_count;
            target_q <= next_target;
        end
    end

    // Next-state logic: requests are only honoured in the state that owns them.
    // Stop beats reaching target, and load beats start in IDLE.
    always_comb begin
        next_state  = state;
        next_count  = count;
        next_target = target_q;
        wrap_evt    = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    next_count = load_val;
                end else if (start) begin
                    next_target = target;
                    if (target == count) begin
                        next_state = DONE;
                    end else begin
                        next_state = COUNT;
                    end
                end
            end
            COUNT: begin
                if (stop) begin
                    next_state = IDLE;
                end else begin
                    next_count = inc_s;
                    wrap_evt   = inc_cout;
                    if (inc_s == target_q) begin
                        next_state = DONE;
                    end
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Status flags registered from the next state so they line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
            wrap <= 1'b0;
        end else begin
            busy <= (next_state == COUNT);
            done <= (next_state == DONE);
            wrap <= wrap_evt;
        end
    end

    // Sticky overflow: a wrap on the same edge as clr_ovf keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (wrap_evt) begin
            ovf <= 1'b1;
        end else if (clr_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sixteen_bit_up_counter.sv
// Directed bench for the sixteen-bit up counter: a vector table for the main
// runs plus hand-written sequences for reset, abort, wrap/clear and carry chain.
module tb_sixteen_bit_up_counter;
    import sixteen_bit_up_counter_pkg::*;

    localparam int W = CNT_W;

    // ---------------- clock / reset ----------------
    logic         clk = 1'b0;
    logic         rst;
    logic         load;
    logic [W-1:0] load_val;
    logic         start;
    logic [W-1:0] target;
    logic         stop;
    logic         clr_ovf;
    logic [W-1:0] count;
    logic         busy;
    logic         done;
    logic         wrap;
    logic         ovf;

    always #5 clk = ~clk;

    sixteen_bit_up_counter #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .target   (target),
        .stop     (stop),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .wrap     (wrap),
        .ovf      (ovf)
    );

    // ---------------- scoreboard counters ----------------
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] e_count,
                             input logic e_busy, input logic e_done,
                             input logic e_wrap, input logic e_ovf);
        check({tag, ".count"}, count, e_count);
        check({tag, ".busy"}, W'(busy), W'(e_busy));
        check({tag, ".done"}, W'(done), W'(e_done));
        check({tag, ".wrap"}, W'(wrap), W'(e_wrap));
        check({tag, ".ovf"}, W'(ovf), W'(e_ovf));
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        load     = 1'b0;
        load_val = '0;
        start    = 1'b0;
        target   = '0;
        stop     = 1'b0;
        clr_ovf  = 1'b0;
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        idle_inputs();
        load     = 1'b1;
        load_val = v;
        tick();
        idle_inputs();
    endtask

    task automatic do_start(input logic [W-1:0] t);
        idle_inputs();
        start  = 1'b1;
        target = t;
        tick();
        idle_inputs();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic         ld;
        logic [W-1:0] ld_val;
        logic         st;
        logic [W-1:0] tgt;
        logic         sp;
        logic         clr;
        logic [W-1:0] e_count;
        logic         e_busy;
        logic         e_done;
        logic         e_wrap;
        logic         e_ovf;
    } vec_t;

    localparam int NVEC = 17;
    vec_t vecs[NVEC];

    function automatic vec_t mk(input logic ld, input logic [W-1:0] ld_val,
                                input logic st, input logic [W-1:0] tgt,
                                input logic sp, input logic clr,
                                input logic [W-1:0] e_count, input logic e_busy,
                                input logic e_done, input logic e_wrap, input logic e_ovf);
        vec_t v;
        v.ld = ld; v.ld_val = ld_val; v.st = st; v.tgt = tgt; v.sp = sp; v.clr = clr;
        v.e_count = e_count; v.e_busy = e_busy; v.e_done = e_done;
        v.e_wrap = e_wrap; v.e_ovf = e_ovf;
        return v;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        //                 ld  ld_val    st  tgt       sp  clr  count     bsy dn  wr  ovf
        vecs[0]  = mk(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 1'b0, 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[2]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0011, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[3]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0012, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0013, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[6]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 16'hFFFE, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[12] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        // load and start together: load only
        vecs[13] = mk(1'b1, 16'h1234, 1'b1, 16'h4000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        // start with target == count: immediate DONE, count unchanged
        vecs[14] = mk(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
        vecs[15] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);
        // stop in IDLE is ignored
        vecs[16] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0);

        idle_inputs();
        rst = 1'b1;
        #2;
        check_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #10;
        rst = 1'b0;

        // Table-driven runs: basic count, wrap, load/start priority, immediate done.
        for (int i = 0; i < NVEC; i++) begin
            load     = vecs[i].ld;
            load_val = vecs[i].ld_val;
            start    = vecs[i].st;
            target   = vecs[i].tgt;
            stop     = vecs[i].sp;
            clr_ovf  = vecs[i].clr;
            tick();
            check_all($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_busy,
                      vecs[i].e_done, vecs[i].e_wrap, vecs[i].e_ovf);
        end
        idle_inputs();

        // clr_ovf on the wrap edge: set wins.
        do_load(16'hFFFF);
        do_start(16'h0005);
        check_all("cw_start", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check_all("cw_wrap", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check_all("cw_after", 16'h0001, 1'b1, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_all("cw_stop", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort: count toward 0x0100, poke load/start mid-run, stop at 0x0005.
        do_load(16'h0000);
        do_start(16'h0100);
        check_all("ab_start", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_all("ab_c2", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1);
        load     = 1'b1;
        load_val = 16'h7777;
        start    = 1'b1;
        target   = 16'h0003;
        tick();
        idle_inputs();
        check_all("ab_ignore", 16'h0003, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        check_all("ab_c5", 16'h0005, 1'b1, 1'b0, 1'b0, 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check_all("ab_stop", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_all("ab_hold", 16'h0005, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-COUNT at 0x0123, no clock edge needed.
        do_load(16'h0120);
        do_start(16'h0200);
        tick();
        tick();
        tick();
        check_all("rs_pre", 16'h0123, 1'b1, 1'b0, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        check_all("rs_async", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("rs_post%0d", i), 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        // Carry chain: 2^k - 1 plus one step must give 2^k for every stage.
        for (int k = 1; k < W; k++) begin
            logic [W-1:0] v;
            logic [W-1:0] p;
            p = W'(32'd1 << k);
            v = p - W'(1);
            do_load(v);
            do_start(p);
            tick();
            check($sformatf("carry%0d.count", k), count, p);
            check($sformatf("carry%0d.done", k), W'(done), W'(1'b1));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
